// File: rtl/rtx_pixel_scheduler.sv
// Raster-order ray issue sequencer for the ray-tracing core. It limits rays in flight and pairs
// each in-order result with its framebuffer address through a small address FIFO.
module rtx_pixel_scheduler #(
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 720,
  parameter int MAX_INFLIGHT = 4,
  parameter int ADDR_W       = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              new_ray,
  output logic [10:0]       pixel_h_out,
  output logic [9:0]        pixel_v_out,
  input  logic              ray_done,
  input  logic [15:0]       rtx_pixel,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: new_ray is a one-cycle issue pulse with no back-pressure. The core answers each ray
  // with exactly one ray_done pulse in issue order. fb_we is a one-cycle strobe with no ready.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);
  localparam logic [10:0]      H_LAST   = 11'(WIDTH - 1);
  localparam logic [9:0]       V_LAST   = 10'(HEIGHT - 1);

  state_t            state_q, state_d;
  logic [10:0]       h_q, cur_h;
  logic [9:0]        v_q, cur_v;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [CNT_W-1:0]  inflight;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] fifo_mem [2**PTR_W];
  logic              issue, accept, room, retire, spurious;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign room      = (inflight < MAX_CNT);
  assign retire    = ray_done && (inflight != '0);
  assign spurious  = ray_done && (inflight == '0);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // An accepted start issues pixel (0,0) on the same edge, so the raster position is forced to the
  // origin while idle.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    accept     = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    cur_h      = h_q;
    cur_v      = v_q;
    cur_addr   = addr_q;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        cur_h    = '0;
        cur_v    = '0;
        cur_addr = '0;
        if (start) begin
          accept  = 1'b1;
          issue   = room;
          state_d = ISSUE;
        end
      end
      ISSUE: issue = room;
      DRAIN: if (inflight == '0) state_d = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue && cur_h == H_LAST && cur_v == V_LAST) state_d = DRAIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q         <= '0;
      v_q         <= '0;
      addr_q      <= '0;
      new_ray     <= 1'b0;
      pixel_h_out <= '0;
      pixel_v_out <= '0;
      inflight    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      frame_count <= '0;
      err         <= 1'b0;
    end else begin
      new_ray <= issue;
      fb_we   <= retire;
      if (issue) begin
        pixel_h_out <= cur_h;
        pixel_v_out <= cur_v;
        addr_q      <= cur_addr + ADDR_W'(1);
        wr_ptr      <= ptr_inc(wr_ptr);
        if (cur_h == H_LAST) begin
          h_q <= '0;
          v_q <= cur_v + 10'd1;
        end else begin
          h_q <= cur_h + 11'd1;
          v_q <= cur_v;
        end
      end else if (accept) begin
        h_q    <= '0;
        v_q    <= '0;
        addr_q <= '0;
      end
      if (retire) begin
        fb_addr <= fifo_mem[rd_ptr];
        fb_data <= rtx_pixel;
        rd_ptr  <= ptr_inc(rd_ptr);
      end
      // A simultaneous push and pop leaves the count unchanged.
      case ({issue, retire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (spurious)    err <= 1'b1;
      else if (accept) err <= 1'b0;
      if (state_q == DONE) frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) fifo_mem[wr_ptr] <= cur_addr;
  end

endmodule

// File: tb/tb_rtx_pixel_scheduler.sv
// Three scheduler instances (MAX_INFLIGHT 1, 4, 2) on a 4x2 screen are driven by a modelled core.
// An event-level reference model predicts every output on every cycle.
module tb_rtx_pixel_scheduler;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int AW   = 3;
  localparam int NI   = 3;
  localparam int BIG  = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NI-1:0] start    = '0;
  logic [NI-1:0] ray_done = '0;
  logic [NI-1:0] new_ray, fb_we, busy, frame_done, err;
  logic [10:0]   ph [NI];
  logic [9:0]    pv [NI];
  logic [15:0]   px [NI];
  logic [AW-1:0] fa [NI];
  logic [15:0]   fdat [NI];
  logic [15:0]   fc [NI];
  logic [1:0]    dbg [NI];

  rtx_pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .new_ray(new_ray[0]), .pixel_h_out(ph[0]),
    .pixel_v_out(pv[0]), .ray_done(ray_done[0]), .rtx_pixel(px[0]), .fb_we(fb_we[0]),
    .fb_addr(fa[0]), .fb_data(fdat[0]), .busy(busy[0]), .frame_done(frame_done[0]),
    .frame_count(fc[0]), .err(err[0]), .dbg_state(dbg[0]));
  rtx_pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .new_ray(new_ray[1]), .pixel_h_out(ph[1]),
    .pixel_v_out(pv[1]), .ray_done(ray_done[1]), .rtx_pixel(px[1]), .fb_we(fb_we[1]),
    .fb_addr(fa[1]), .fb_data(fdat[1]), .busy(busy[1]), .frame_done(frame_done[1]),
    .frame_count(fc[1]), .err(err[1]), .dbg_state(dbg[1]));
  rtx_pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .new_ray(new_ray[2]), .pixel_h_out(ph[2]),
    .pixel_v_out(pv[2]), .ray_done(ray_done[2]), .rtx_pixel(px[2]), .fb_we(fb_we[2]),
    .fb_addr(fa[2]), .fb_data(fdat[2]), .busy(busy[2]), .frame_done(frame_done[2]),
    .frame_count(fc[2]), .err(err[2]), .dbg_state(dbg[2]));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int lat [NI];
  int start_req [NI] = '{0, 0, 0};
  int start_ack [NI] = '{0, 0, 0};
  int spur_req  [NI] = '{0, 0, 0};
  int spur_ack  [NI] = '{0, 0, 0};

  // Reference model: frame start cycle, frame_done cycle, issue/return counts and event times.
  int          m_bs [NI];
  int          m_fd [NI];
  int          m_niss [NI];
  int          m_nret [NI];
  int          m_fc [NI];
  bit          m_err [NI];
  bit          m_we [NI];
  int          m_waddr [NI];
  logic [15:0] m_wdata [NI];
  int          m_iss [NI][NPIX];
  int          m_ret [NI][NPIX];
  bit          post_rst = 1'b0;

  function automatic int max_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 2);
  endfunction

  task automatic chk(input int inst, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL i%0d %s: got %0h expected %0h", inst, tag, obs, exp);
    end
  endtask

  // Sample outputs on the falling edge, then drive the core inputs for the next rising edge.
  always @(negedge clk) begin
    bit busy_e, exp_iss, ok, do_ret, do_spur, do_st;
    int n, e;
    logic [15:0] d;
    cyc++;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        m_bs[i] = -1; m_fd[i] = BIG; m_niss[i] = 0; m_nret[i] = 0;
        m_fc[i] = 0; m_err[i] = 1'b0; m_we[i] = 1'b0;
        start_ack[i] = start_req[i];
        spur_ack[i]  = spur_req[i];
      end
      start    = '0;
      ray_done = '0;
      post_rst = 1'b1;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (post_rst) begin
          chk(i, "rst_pixel_h", 32'(ph[i]), 0);
          chk(i, "rst_pixel_v", 32'(pv[i]), 0);
          chk(i, "rst_fb_addr", 32'(fa[i]), 0);
          chk(i, "rst_fb_data", 32'(fdat[i]), 0);
        end
        busy_e = (m_bs[i] >= 0) && (cyc > m_bs[i]) && (cyc <= m_fd[i]);
        chk(i, "busy", 32'(busy[i]), 32'(busy_e));
        chk(i, "frame_done", 32'(frame_done[i]), 32'(cyc == m_fd[i]));
        chk(i, "fb_we", 32'(fb_we[i]), 32'(m_we[i]));
        if (m_we[i]) begin
          chk(i, "fb_addr", 32'(fa[i]), 32'(m_waddr[i]));
          chk(i, "fb_data", 32'(fdat[i]), 32'(m_wdata[i]));
        end
        chk(i, "err", 32'(err[i]), 32'(m_err[i]));
        chk(i, "frame_count", 32'(fc[i]), m_fc[i] & 32'hffff);
        // Issue n lands one cycle after issue n-1, and never before the cycle after the write of
        // ray n-MAX.
        exp_iss = 1'b0;
        n = m_niss[i];
        if (m_bs[i] >= 0 && n < NPIX) begin
          e  = (n == 0) ? m_bs[i] + 1 : m_iss[i][n-1] + 1;
          ok = 1'b1;
          if (n >= max_of(i)) begin
            if (m_nret[i] > n - max_of(i)) begin
              if (m_ret[i][n-max_of(i)] + 2 > e) e = m_ret[i][n-max_of(i)] + 2;
            end else ok = 1'b0;
          end
          exp_iss = ok && (cyc == e);
        end
        chk(i, "new_ray", 32'(new_ray[i]), 32'(exp_iss));
        if (exp_iss) begin
          chk(i, "pixel_h", 32'(ph[i]), n % W);
          chk(i, "pixel_v", 32'(pv[i]), n / W);
          m_iss[i][n] = cyc;
          m_niss[i]++;
        end
        if (cyc == m_fd[i]) m_fc[i]++;
        m_we[i] = 1'b0;
        do_st = (start_req[i] > start_ack[i]);
        if (do_st) start_ack[i]++;
        start[i] = do_st;
        if (do_st && !busy_e) begin
          m_bs[i] = cyc; m_fd[i] = BIG; m_niss[i] = 0; m_nret[i] = 0; m_err[i] = 1'b0;
        end
        do_ret  = (m_nret[i] < m_niss[i]) && (cyc == m_iss[i][m_nret[i]] + lat[i]);
        do_spur = (spur_req[i] > spur_ack[i]) && !do_ret;
        if (do_spur) spur_ack[i]++;
        d = 16'($urandom_range(0, 65535));
        px[i] = d;
        ray_done[i] = do_ret || do_spur;
        if (ray_done[i]) begin
          if (m_niss[i] > m_nret[i]) begin
            m_we[i] = 1'b1; m_waddr[i] = m_nret[i]; m_wdata[i] = d;
            m_ret[i][m_nret[i]] = cyc;
            m_nret[i]++;
            if (m_nret[i] == NPIX) m_fd[i] = cyc + 2;
          end else m_err[i] = 1'b1;
        end
      end
      post_rst = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    lat = '{5, 10, 1};
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(3);
    // Throttled, full-throughput and coincident push/pop frames in parallel.
    for (int i = 0; i < NI; i++) start_req[i]++;
    wait_cyc(80);
    // Second start mid-frame must be ignored.
    start_req[1]++;
    wait_cyc(4);
    start_req[1]++;
    wait_cyc(60);
    // Spurious return while idle, then a start clears the flag.
    spur_req[0]++;
    wait_cyc(3);
    start_req[0]++;
    wait_cyc(80);
    // Random core latencies and staggered starts.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) lat[i] = $urandom_range(1, 12);
      for (int i = 0; i < NI; i++) begin
        start_req[i]++;
        wait_cyc($urandom_range(0, 3));
      end
      wait_cyc(130);
    end
    // Reset after three issues, stale returns, then a clean frame.
    lat[0] = 5;
    start_req[0]++;
    wait_cyc(17);
    rst = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(2);
    spur_req[0]++;
    wait_cyc(2);
    spur_req[0]++;
    wait_cyc(3);
    start_req[0]++;
    wait_cyc(80);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rtx_pixel_scheduler.md
# rtx_pixel_scheduler

Frame-level sequencer that sits directly upstream and downstream of the ray-tracing core. It walks the screen in raster order and issues one `new_ray` pulse per pixel with its coordinates. It throttles issue to a bounded number of in-flight rays and pairs each returning `ray_done`/`rtx_pixel` with the address of the pixel it belongs to. The core does not return coordinates, so the block keeps an in-order address FIFO and emits framebuffer write strobes.

## Interface

Parameters:
- `WIDTH`, default 1280: pixels per line.
- `HEIGHT`, default 720: lines per frame.
- `MAX_INFLIGHT`, default 4: maximum rays issued but not yet returned; also the address FIFO depth (≥1).
- `ADDR_W`, default `$clog2(WIDTH*HEIGHT)`: framebuffer address width.

Ports (clock and reset first):
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a frame; ignored unless in IDLE.
- `new_ray` out 1: one-cycle issue pulse to the core.
- `pixel_h_out` out 11: column of the issued ray; valid with `new_ray`, held until the next issue.
- `pixel_v_out` out 10: row of the issued ray; same timing as `pixel_h_out`.
- `ray_done` in 1: result-valid pulse from the core; results return in issue order.
- `rtx_pixel` in 16: RGB565 result, sampled when `ray_done` is high.
- `fb_we` out 1: framebuffer write strobe.
- `fb_addr` out ADDR_W: write address, equal to v*WIDTH+h.
- `fb_data` out 16: write data.
- `busy` out 1: high in ISSUE, DRAIN and DONE.
- `frame_done` out 1: one-cycle pulse at frame end.
- `frame_count` out 16: count of completed frames; wraps at 2^16.
- `err` out 1: sticky flag, set by a `ray_done` arriving with an empty FIFO; cleared by an accepted `start`.

## Operation

- **Reset values:** all outputs 0, FSM in IDLE, h/v/address counters 0, inflight 0, FIFO empty.
- **FSM IDLE:** on `start`, clear h, v, address counter and `err`, then go to ISSUE.
- **FSM ISSUE:** on each cycle where registered inflight < MAX_INFLIGHT:
  - assert `new_ray` with the current h/v;
  - push the address counter into the FIFO;
  - increment inflight;
  - advance the raster: h wraps at WIDTH-1 and v increments; the address counter increments by 1.
- **Leaving ISSUE:** once pixel (WIDTH-1, HEIGHT-1) has been issued, go to DRAIN.
- **FSM DRAIN:** when inflight == 0, go to DONE.
- **FSM DONE:** one cycle. `frame_done`=1 and `frame_count` increments; then return to IDLE.
- **Retire (any state):**
  - `ray_done` with a non-empty FIFO: pop the head, register `fb_addr`=head, `fb_data`=`rtx_pixel`, `fb_we`=1 on the next cycle, decrement inflight.
  - `ray_done` with an empty FIFO: no write, no count change, set `err`.
- **Simultaneous issue and retire:** inflight is unchanged and the FIFO pushes and pops together. A slot freed by a retire is usable only on the following cycle, because the issue decision uses registered inflight.
- `start` while `busy` is ignored and does not disturb the frame.
- **Reset mid-frame:** everything returns to the reset values immediately. Stale `ray_done` pulses arriving afterwards set `err` and produce no `fb_we`.

## Timing

- `new_ray`, `pixel_h_out` and `pixel_v_out` are registered. The first issue occurs 1 cycle after the `start` cycle.
- With MAX_INFLIGHT ≥ 2 and no backpressure, the block issues one ray per cycle.
- With MAX_INFLIGHT=1, the next issue occurs no earlier than 1 cycle after the `fb_we` of the previous ray.
- `fb_we`, `fb_addr` and `fb_data` are valid exactly 1 cycle after `ray_done`, for 1 cycle.
- `frame_done` is high exactly 2 cycles after the final `ray_done`, i.e. 1 cycle after the last `fb_we`. `frame_count` shows the new value on the cycle after `frame_done`.
- `busy` rises 1 cycle after an accepted `start` and falls the cycle after `frame_done`.

## Test plan

All scenarios use WIDTH=4, HEIGHT=2.

- **Throttled single frame (MAX_INFLIGHT=1):** `start`, core returns `ray_done` 5 cycles after each `new_ray` with `rtx_pixel`=0x1000+index → 8 issues with (h,v)=(0,0),(1,0)..(3,1); `fb_addr` 0..7 with matching data; `frame_done` once, 2 cycles after the 8th `ray_done`; `frame_count`=1; `err`=0.
- **Full throughput (MAX_INFLIGHT=4):** core latency 10 cycles → exactly 4 back-to-back issues, a stall until the first retire, never more than 4 outstanding; addresses in order 0..7.
- **Simultaneous push/pop (MAX_INFLIGHT=2):** core latency 1 → each retire coincides with an issue; FIFO never overflows; write order is preserved.
- **Start while busy:** second `start` mid-frame → no restart, 8 writes total, `frame_count` increments by 1.
- **Spurious return:** `ray_done` in IDLE → `err`=1, no `fb_we`; a following `start` clears `err`.
- **Reset mid-frame:** assert `rst` low after 3 issues, release, send 2 stale `ray_done` → `err`=1, no writes. A new `start` then runs a full frame beginning at address 0.
